// File: rtl/ad_ip_jesd204_tpl_adc_pkg.sv
// Shared definitions for the JESD204 ADC transport-layer register map and
// the PN scan sequencer: per-channel register offsets, status bit
// positions, scan FSM state encoding and address/data helpers.
package ad_ip_jesd204_tpl_adc_pkg;

  localparam logic [13:0] CHAN_BASE        = 14'h0100;
  localparam int          CHAN_STRIDE      = 16;
  localparam int          REG_CHAN_STATUS  = 1;
  localparam int          REG_CHAN_CNTRL_3 = 6;

  // STATUS bits (write-1-to-clear)
  localparam int STATUS_OVER_RANGE = 0;
  localparam int STATUS_PN_OOS     = 1;
  localparam int STATUS_PN_ERR     = 2;
  localparam logic [31:0] STATUS_CLEAR_ALL = 32'h0000_0007;

  // CNTRL_3 pnseq_sel field occupies [19:16]
  localparam int CNTRL_3_PNSEQ_LSB = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SEL,
    S_SETTLE,
    S_WR_CLR,
    S_DWELL,
    S_RD_STAT,
    S_NEXT,
    S_DONE
  } pn_scan_state_e;

  function automatic logic [13:0] chan_addr(input int ch, input int reg_off);
    return CHAN_BASE + 14'(CHAN_STRIDE * ch + reg_off);
  endfunction

  function automatic logic [31:0] cntrl_3_word(input logic [3:0] pnseq_sel);
    return 32'(pnseq_sel) << CNTRL_3_PNSEQ_LSB;
  endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_up_req.sv
// Single outstanding up_* bus request engine.
// A one-cycle 'issue' registers a request pulse (read or write) together
// with its address/data, then waits for the matching acknowledge. Address
// and data registers hold until the next issue, so they are stable from the
// request cycle through the ack. An ack in the request cycle itself is
// accepted; acks seen while not waiting, or of the other kind, are ignored.
// Ports:
//   up_clk, up_rstn          clock, synchronous active-low reset
//   issue, issue_read        start a request (read when issue_read=1)
//   issue_addr, issue_data   address / write data for the new request
//   ack_ok                   ack accepted this cycle (combinational)
//   ack_timeout              no ack within ACK_TIMEOUT cycles (combinational)
//   up_wreq/up_waddr/up_wdata/up_wack   write channel
//   up_rreq/up_raddr/up_rack            read channel
module ad_ip_jesd204_tpl_up_req #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        up_clk,
  input  logic        up_rstn,
  input  logic        issue,
  input  logic        issue_read,
  input  logic [13:0] issue_addr,
  input  logic [31:0] issue_data,
  output logic        ack_ok,
  output logic        ack_timeout,
  output logic        up_wreq,
  output logic [13:0] up_waddr,
  output logic [31:0] up_wdata,
  input  logic        up_wack,
  output logic        up_rreq,
  output logic [13:0] up_raddr,
  input  logic        up_rack
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic             waiting;
  logic             is_read;
  logic [CNT_W-1:0] cnt;
  logic             ack;

  assign ack         = is_read ? up_rack : up_wack;
  assign ack_ok      = waiting & ack;
  // cnt is 0 in the request cycle, so the last accepted ack is at cnt = ACK_TIMEOUT-1
  assign ack_timeout = waiting & ~ack & (cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      waiting  <= 1'b0;
      is_read  <= 1'b0;
      cnt      <= '0;
      up_wreq  <= 1'b0;
      up_rreq  <= 1'b0;
      up_waddr <= '0;
      up_raddr <= '0;
      up_wdata <= '0;
    end else begin
      up_wreq <= 1'b0;
      up_rreq <= 1'b0;
      if (issue) begin
        waiting <= 1'b1;
        is_read <= issue_read;
        cnt     <= '0;
        if (issue_read) begin
          up_rreq  <= 1'b1;
          up_raddr <= issue_addr;
        end else begin
          up_wreq  <= 1'b1;
          up_waddr <= issue_addr;
          up_wdata <= issue_data;
        end
      end else if (waiting) begin
        if (ack_ok || ack_timeout) waiting <= 1'b0;
        else                       cnt     <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_pn_scan.sv
// Autonomous PN-sequence check sequencer. For each channel it writes the PN
// select into CNTRL_3, waits SETTLE_CYCLES, clears STATUS, dwells
// DWELL_CYCLES, reads STATUS back and records pass = no pn_err and no
// pn_oos. A missed ack sets the sticky timeout flag and ends the scan.
// Ports:
//   up_clk, up_rstn      clock, synchronous active-low reset
//   start, pn_sel        scan request (IDLE only) and PN code to program
//   busy, done           scan in progress / one-cycle end pulse
//   pass, timeout        per-channel result vector / missed-ack flag
//   up_w*, up_r*         master side of the TPL up_* register bus
module ad_ip_jesd204_tpl_adc_pn_scan
  import ad_ip_jesd204_tpl_adc_pkg::*;
#(
  parameter int NUM_CHANNELS  = 1,
  parameter int SETTLE_CYCLES = 256,
  parameter int DWELL_CYCLES  = 4096,
  parameter int ACK_TIMEOUT   = 64
) (
  input  logic                    up_clk,
  input  logic                    up_rstn,
  input  logic                    start,
  input  logic [3:0]              pn_sel,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CHANNELS-1:0] pass,
  output logic                    timeout,
  output logic                    up_wreq,
  output logic [13:0]             up_waddr,
  output logic [31:0]             up_wdata,
  input  logic                    up_wack,
  output logic                    up_rreq,
  output logic [13:0]             up_raddr,
  input  logic [31:0]             up_rdata,
  input  logic                    up_rack
);

  localparam int CH_W     = $clog2(NUM_CHANNELS) + 1;
  localparam int WAIT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX) + 1;
  localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CHANNELS - 1);
  localparam logic [WAIT_W-1:0] SETTLE_END = WAIT_W'(SETTLE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] DWELL_END  = WAIT_W'(DWELL_CYCLES - 1);

  pn_scan_state_e    state, state_next;
  logic [CH_W-1:0]   ch;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        pn_sel_q;
  logic              issue, issue_read;
  logic [13:0]       issue_addr;
  logic [31:0]       issue_data;
  logic              ack_ok, ack_timeout;
  logic              chan_clean;
  logic              unused_rdata;

  assign chan_clean   = ~(up_rdata[STATUS_PN_ERR] | up_rdata[STATUS_PN_OOS]);
  assign unused_rdata = ^{up_rdata[31:STATUS_PN_ERR + 1], up_rdata[STATUS_OVER_RANGE]};

  // Requests are issued on the transition into a bus state so the pulse is
  // visible in that state's first cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that left
    // one unassigned would infer a latch.
    state_next = state;
    issue      = 1'b0;
    issue_read = 1'b0;
    issue_addr = '0;
    issue_data = '0;
    case (state)
      S_IDLE: if (start) begin
        // pn_sel_q and ch are not loaded yet: use the live inputs/channel 0
        state_next = S_WR_SEL;
        issue      = 1'b1;
        issue_addr = chan_addr(0, REG_CHAN_CNTRL_3);
        issue_data = cntrl_3_word(pn_sel);
      end
      S_WR_SEL: begin
        if (ack_timeout) state_next = S_DONE;
        else if (ack_ok) state_next = S_SETTLE;
      end
      S_SETTLE: if (wait_cnt == SETTLE_END) begin
        state_next = S_WR_CLR;
        issue      = 1'b1;
        issue_addr = chan_addr(int'(ch), REG_CHAN_STATUS);
        issue_data = STATUS_CLEAR_ALL;
      end
      S_WR_CLR: begin
        if (ack_timeout) state_next = S_DONE;
        else if (ack_ok) state_next = S_DWELL;
      end
      S_DWELL: if (wait_cnt == DWELL_END) begin
        state_next = S_RD_STAT;
        issue      = 1'b1;
        issue_read = 1'b1;
        issue_addr = chan_addr(int'(ch), REG_CHAN_STATUS);
      end
      S_RD_STAT: begin
        if (ack_timeout) state_next = S_DONE;
        else if (ack_ok) state_next = S_NEXT;
      end
      S_NEXT: begin
        if (ch == LAST_CH) begin
          state_next = S_DONE;
        end else begin
          state_next = S_WR_SEL;
          issue      = 1'b1;
          issue_addr = chan_addr(int'(ch) + 1, REG_CHAN_CNTRL_3);
          issue_data = cntrl_3_word(pn_sel_q);
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // busy/done are registered from state_next so they line up with the state
  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      ch       <= '0;
      wait_cnt <= '0;
      pn_sel_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= '0;
      timeout  <= 1'b0;
    end else begin
      wait_cnt <= (state_next != state) ? '0 : wait_cnt + 1'b1;
      busy     <= (state_next != S_IDLE) && (state_next != S_DONE);
      done     <= (state_next == S_DONE);
      if (state == S_IDLE && start) begin
        pn_sel_q <= pn_sel;
        ch       <= '0;
        pass     <= '0;
        timeout  <= 1'b0;
      end
      if (ack_timeout) timeout <= 1'b1;
      if (state == S_RD_STAT && ack_ok) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          if (CH_W'(i) == ch) pass[i] <= chan_clean;
        end
      end
      if (state == S_NEXT && state_next == S_WR_SEL) ch <= ch + 1'b1;
    end
  end

  ad_ip_jesd204_tpl_up_req #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) i_up_req (
    .up_clk      (up_clk),
    .up_rstn     (up_rstn),
    .issue       (issue),
    .issue_read  (issue_read),
    .issue_addr  (issue_addr),
    .issue_data  (issue_data),
    .ack_ok      (ack_ok),
    .ack_timeout (ack_timeout),
    .up_wreq     (up_wreq),
    .up_waddr    (up_waddr),
    .up_wdata    (up_wdata),
    .up_wack     (up_wack),
    .up_rreq     (up_rreq),
    .up_raddr    (up_raddr),
    .up_rack     (up_rack)
  );

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_scan.sv
// Self-checking bench for ad_ip_jesd204_tpl_adc_pn_scan.
// A scan model builds the expected request schedule (cycle, kind, address,
// data) and the done cycle / pass / timeout from the channel sequence, and a
// compare process checks every bus/status output each cycle against it.
// Literal scan lengths and pass vectors per test pin the model. A second,
// zero-latency instance with SETTLE=DWELL=1 checks the cycle formula.
module tb_ad_ip_jesd204_tpl_adc_pn_scan;

  localparam int NCH = 4;
  localparam int S   = 3;
  localparam int D   = 5;
  localparam int TO  = 8;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [13:0] addr;
    logic [31:0] data;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn, start;
  logic [3:0]        pn_sel;
  logic              busy, done, timeout;
  logic [NCH-1:0]    pass;
  logic              up_wreq, up_wack, up_rreq, up_rack;
  logic [13:0]       up_waddr, up_raddr;
  logic [31:0]       up_wdata, up_rdata;

  ad_ip_jesd204_tpl_adc_pn_scan #(
    .NUM_CHANNELS (NCH), .SETTLE_CYCLES (S), .DWELL_CYCLES (D), .ACK_TIMEOUT (TO)
  ) u_dut (
    .up_clk (clk), .up_rstn (rstn), .start (start), .pn_sel (pn_sel),
    .busy (busy), .done (done), .pass (pass), .timeout (timeout),
    .up_wreq (up_wreq), .up_waddr (up_waddr), .up_wdata (up_wdata), .up_wack (up_wack),
    .up_rreq (up_rreq), .up_raddr (up_raddr), .up_rdata (up_rdata), .up_rack (up_rack)
  );

  // zero-latency instance: acks are the request pulses themselves
  logic           f_start, f_busy, f_done, f_timeout, f_wreq, f_rreq;
  logic [NCH-1:0] f_pass;
  logic [13:0]    f_waddr, f_raddr;
  logic [31:0]    f_wdata;
  logic [3:0]     f_pn_sel = 4'h9;
  logic [31:0]    f_rdata  = 32'h0;

  ad_ip_jesd204_tpl_adc_pn_scan #(
    .NUM_CHANNELS (NCH), .SETTLE_CYCLES (1), .DWELL_CYCLES (1), .ACK_TIMEOUT (TO)
  ) u_dut_fast (
    .up_clk (clk), .up_rstn (rstn), .start (f_start), .pn_sel (f_pn_sel),
    .busy (f_busy), .done (f_done), .pass (f_pass), .timeout (f_timeout),
    .up_wreq (f_wreq), .up_waddr (f_waddr), .up_wdata (f_wdata), .up_wack (f_wreq),
    .up_rreq (f_rreq), .up_raddr (f_raddr), .up_rdata (f_rdata), .up_rack (f_rreq)
  );

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  req_t        exp_q[$];
  int          t0 = -100, done_cyc = -99, done_seen = -1;
  logic [3:0]  exp_pass = '0;
  bit          exp_to = 1'b0;
  bit          chk_en = 1'b0;
  int          lat = 0, drop_ch = -1;
  bit          stray_en = 1'b0;
  logic [31:0] st[NCH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Scan model: walk the channel sequence and place each request at its cycle.
  task automatic plan(input logic [3:0] pn, input int l, input int drop, input int t_start);
    int   t;
    req_t r;
    exp_q.delete();
    t0 = t_start; exp_pass = '0; exp_to = 1'b0; done_seen = -1;
    t = t_start + 1;
    for (int c = 0; c < NCH; c++) begin
      r.cyc = t; r.rd = 1'b0; r.addr = 14'h100 + 14'(16 * c + 6); r.data = {12'h0, pn, 16'h0};
      exp_q.push_back(r);
      t += l + 1 + S;
      r.cyc = t; r.rd = 1'b0; r.addr = 14'h100 + 14'(16 * c + 1); r.data = 32'h7;
      exp_q.push_back(r);
      if (c == drop) begin
        done_cyc = t + TO;
        exp_to   = 1'b1;
        return;
      end
      t += l + 1 + D;
      r.cyc = t; r.rd = 1'b1; r.addr = 14'h100 + 14'(16 * c + 1); r.data = '0;
      exp_q.push_back(r);
      t += l + 1;
      if (st[c][2:1] == 2'b00) exp_pass[c] = 1'b1;
      t += 1;
    end
    done_cyc = t;
  endtask

  task automatic plan_idle();
    exp_q.delete();
    t0 = -100; done_cyc = -99; exp_pass = '0; exp_to = 1'b0;
  endtask

  // Bus responder: ack each request after 'lat' cycles (0 = same cycle).
  initial begin
    bit          pend, prd;
    logic [13:0] paddr;
    int          cd;
    pend = 1'b0; prd = 1'b0; paddr = '0; cd = 0;
    up_wack = 1'b0; up_rack = 1'b0; up_rdata = '0;
    forever begin
      @(posedge clk); #1;
      up_wack = 1'b0; up_rack = 1'b0; up_rdata = '0;
      if (up_wreq || up_rreq) begin
        pend = 1'b1; prd = up_rreq; paddr = up_rreq ? up_raddr : up_waddr; cd = lat;
      end
      if (pend) begin
        if (cd == 0) begin
          pend = 1'b0;
          if (!(drop_ch >= 0 && !prd && paddr == 14'h100 + 14'(16 * drop_ch + 1))) begin
            if (prd) begin
              up_rack  = 1'b1;
              up_rdata = st[int'((paddr - 14'h100) >> 4) & 3];
            end else begin
              up_wack = 1'b1;
            end
          end
        end else begin
          cd--;
        end
      end else if (stray_en) begin
        up_wack = 1'b1; up_rack = 1'b1; up_rdata = 32'h6;
      end
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    bit exp_wr, exp_rd;
    @(negedge clk);
    if (chk_en) begin
      exp_wr = 1'b0; exp_rd = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_rd = exp_q[0].rd;
        exp_wr = !exp_q[0].rd;
        if (exp_rd) begin
          check("raddr", up_raddr, exp_q[0].addr);
        end else begin
          check("waddr", up_waddr, exp_q[0].addr);
          check("wdata", up_wdata, exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end
      check("wreq", up_wreq, exp_wr);
      check("rreq", up_rreq, exp_rd);
      check("busy", busy, (cyc > t0) && (cyc < done_cyc));
      check("done", done, cyc == done_cyc);
      if (done) done_seen = cyc;
      if (cyc >= done_cyc) begin
        check("pass", pass, exp_pass);
        check("timeout", timeout, exp_to);
      end else if (cyc > t0) begin
        check("timeout during scan", timeout, 1'b0);
      end
    end
  end

  task automatic run_scan(input logic [3:0] pn, input int l, input int drop,
                          input int pin_len, input logic [3:0] pin_pass, input bit pin_to);
    @(negedge clk);
    lat = l; drop_ch = drop;
    plan(pn, l, drop, cyc);
    start = 1'b1; pn_sel = pn;
    @(negedge clk);
    start = 1'b0; pn_sel = ~pn;
    while (cyc < done_cyc + 3) @(negedge clk);
    check("all requests issued", exp_q.size(), 0);
    check("scan length", done_seen - t0, pin_len);
    check("pass literal", pass, pin_pass);
    check("timeout literal", timeout, pin_to);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ft0, fb, fw, fr, fd;
    rstn = 1'b0; start = 1'b0; pn_sel = '0; f_start = 1'b0;
    st = '{default: 32'h0};
    repeat (3) @(negedge clk);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst pass", pass, 4'h0);
    check("rst timeout", timeout, 1'b0);
    check("rst wreq", up_wreq, 1'b0);
    check("rst rreq", up_rreq, 1'b0);
    check("rst waddr", up_waddr, 14'h0);
    check("rst raddr", up_raddr, 14'h0);
    check("rst wdata", up_wdata, 32'h0);
    rstn = 1'b1;
    plan_idle();
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // all clean, L=2: 4 x (9+3+5+1) + 1
    run_scan(4'h5, 2, -1, 73, 4'b1111, 1'b0);
    // channel 2 pn_err
    st[2] = 32'h4;
    run_scan(4'hA, 2, -1, 73, 4'b1011, 1'b0);
    // channel 1 pn_oos, zero latency
    st = '{default: 32'h0}; st[1] = 32'h2;
    run_scan(4'h3, 0, -1, 49, 4'b1101, 1'b0);
    // channel 1 over-range only still passes; ack at the last allowed cycle
    st[1] = 32'h1;
    run_scan(4'hC, TO - 1, -1, 133, 4'b1111, 1'b0);
    // missed WR_CLR ack on channel 1
    st = '{default: 32'h0};
    run_scan(4'h7, 2, 1, 33, 4'b0001, 1'b1);
    // stray acks outside waits; timeout cleared by the new start
    stray_en = 1'b1;
    run_scan(4'h2, 2, -1, 73, 4'b1111, 1'b0);
    stray_en = 1'b0;

    // start while busy ignored, then reset mid-DWELL of channel 1
    @(negedge clk);
    lat = 2; drop_ch = -1;
    plan(4'h6, 2, -1, cyc);
    start = 1'b1; pn_sel = 4'h6;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 5) @(negedge clk);
    start = 1'b1; pn_sel = 4'hF;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 30) @(negedge clk);
    chk_en = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("mid rst busy", busy, 1'b0);
    check("mid rst done", done, 1'b0);
    check("mid rst pass", pass, 4'h0);
    check("mid rst timeout", timeout, 1'b0);
    check("mid rst wreq", up_wreq, 1'b0);
    check("mid rst rreq", up_rreq, 1'b0);
    check("mid rst waddr", up_waddr, 14'h0);
    check("mid rst raddr", up_raddr, 14'h0);
    check("mid rst wdata", up_wdata, 32'h0);
    plan_idle();
    chk_en = 1'b1;
    repeat (20) @(negedge clk);
    run_scan(4'h9, 1, -1, 61, 4'b1111, 1'b0);

    // zero-latency, SETTLE=DWELL=1: 4 x (3+1+1+1) busy cycles, done one later
    chk_en = 1'b0;
    fb = 0; fw = 0; fr = 0; fd = -1;
    @(negedge clk);
    f_start = 1'b1; ft0 = cyc;
    @(negedge clk);
    f_start = 1'b0;
    repeat (40) begin
      if (f_busy) fb++;
      if (f_wreq) fw++;
      if (f_rreq) fr++;
      if (f_done) fd = cyc;
      @(negedge clk);
    end
    check("fast done cycle", fd - ft0, 25);
    check("fast busy cycles", fb, 24);
    check("fast writes", fw, 8);
    check("fast reads", fr, 4);
    check("fast pass", f_pass, 4'b1111);
    check("fast timeout", f_timeout, 1'b0);
    check("fast last waddr", f_waddr, 14'h131);
    check("fast last raddr", f_raddr, 14'h131);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ad_ip_jesd204_tpl_adc_pn_scan.md
# ad_ip_jesd204_tpl_adc_pn_scan

Autonomous PN-sequence check sequencer for the JESD204 ADC transport layer. It masters the internal up_* register bus of the TPL register map and, per channel, programs the PN monitor, clears sticky status, dwells, and reads back error/out-of-sync flags. It produces a per-channel pass vector without processor involvement, so link bring-up can self-test before software attaches.

## Interface
Parameters:
- NUM_CHANNELS, 1: channels scanned, 1..16.
- SETTLE_CYCLES, 256: wait after PN select write before clearing status, ≥1.
- DWELL_CYCLES, 4096: observation window after status clear, ≥1.
- ACK_TIMEOUT, 64: max cycles from request to ack, ≥2.

Ports:
- up_clk  in  1  bus and sequencer clock; all logic on rising edge.
- up_rstn  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  begin a scan; sampled only in IDLE.
- pn_sel  in  4  PN sequence code written to every channel; captured at start.
- busy  out  1  high from the cycle after start acceptance until DONE.
- done  out  1  one-cycle pulse at scan end.
- pass  out  NUM_CHANNELS  bit i = 1 if channel i saw no pn_err/pn_oos; valid when done, held until next start.
- timeout  out  1  sticky; set when an ack is missed; cleared on next accepted start.
- up_wreq  out  1  write request, one-cycle pulse.
- up_waddr  out  14  word address.
- up_wdata  out  32  write data.
- up_wack  in  1  write acknowledge.
- up_rreq  out  1  read request, one-cycle pulse.
- up_raddr  out  14  word address.
- up_rdata  in  32  read data, valid with up_rack.
- up_rack  in  1  read acknowledge.

## Operation
- Channel register base: 14'h0100 + 16·ch. CNTRL_3 at base+6 (pnseq_sel in [19:16]); STATUS at base+1 (bit2 pn_err, bit1 pn_oos, bit0 or; write-1-to-clear).
- States: IDLE → WR_SEL → SETTLE → WR_CLR → DWELL → RD_STAT → NEXT → (WR_SEL | DONE) → IDLE.
- IDLE: on start=1, capture pn_sel, ch=0, pass=0, timeout=0, go WR_SEL.
- WR_SEL: pulse up_wreq, up_waddr=base+6, up_wdata={12'h0, pn_sel, 16'h0}; wait up_wack.
- SETTLE: count SETTLE_CYCLES, then WR_CLR.
- WR_CLR: pulse up_wreq, up_waddr=base+1, up_wdata=32'h7; wait up_wack.
- DWELL: count DWELL_CYCLES, then RD_STAT.
- RD_STAT: pulse up_rreq, up_raddr=base+1; on up_rack, pass[ch] = ~(up_rdata[2] | up_rdata[1]).
- NEXT: if ch==NUM_CHANNELS-1 go DONE, else ch+1 and WR_SEL.
- DONE: done=1 one cycle, busy drops same cycle, return IDLE.
- Ack timeout: counter starts on request cycle; if ack not seen within ACK_TIMEOUT cycles, set timeout, leave pass bits of current and later channels 0, go DONE.
- Ack arriving in the same cycle as the request pulse is accepted. Stray ack outside a wait state is ignored. Reads never coincide with writes.
- start while busy is ignored. Reset mid-scan aborts immediately: no further requests are issued. The PN select already written stays programmed in the regmap.

## Timing
- Reset values: busy=0, done=0, pass=0, timeout=0, up_wreq=0, up_rreq=0, up_waddr=0, up_raddr=0, up_wdata=0.
- All outputs are registered. Address and data are stable from the request cycle until the ack.
- start at cycle T → up_wreq at T+1, busy=1 at T+1.
- Per-channel duration with ack latency L: 3·(L+1) + SETTLE_CYCLES + DWELL_CYCLES + 1 cycles.
- Counters are sized $clog2(max)+1. ch is $clog2(NUM_CHANNELS)+1 bits to avoid wrap at NUM_CHANNELS=16.

## Structure
- Shared package ad_ip_jesd204_tpl_adc_pkg holds state enum, CHAN_BASE (14'h0100), CHAN_STRIDE (16), REG_CHAN_STATUS (1), REG_CHAN_CNTRL_3 (6), and STATUS bit positions. The register map uses the same package.
- One sub-module is natural: ad_ip_jesd204_tpl_up_req. It issues a single-request pulse, waits for ack, and runs the timeout counter; the FSM uses it for both read and write.

## Test plan
- NUM_CHANNELS=4, responder acks at L=2 returning status 0 → writes to 0x106, 0x101, 0x116, …; wdata 0x000N0000 for pn_sel=N; done after 4 channels; pass=4'b1111.
- Channel 2 returns STATUS=0x4 → pass=4'b1011, timeout=0.
- Channel 1 returns STATUS=0x2 → pass[1]=0; STATUS=0x1 (over-range only) → pass[1]=1.
- Responder drops up_wack on channel 1 WR_CLR → timeout=1 after ACK_TIMEOUT cycles, pass=4'b0001, done pulses, no further requests.
- Assert start mid-scan, then up_rstn=0 for one cycle mid-DWELL → start ignored; all outputs take reset values next edge; new start runs a full scan.
- Zero-latency ack (same cycle as request) with SETTLE=DWELL=1 → total cycles match the formula.
